// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART blocks.
// The divider helper rounds to the nearest integer clock count per tick.
package uart_pkg;

   typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

   typedef struct packed {
      logic parity_err;
      logic frame_err;
      logic break_det;
   } rx_flags_t;

   function automatic int uart_div(input longint clk_freq, input longint baud, input int os);
      longint den;
      den = baud * longint'(os);
      return int'((clk_freq + den / 2) / den);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clock tick every DIV clocks.
// Down-counter reloads at terminal count so the tick period is exactly DIV.
module uart_baud_tick #(
   parameter int DIV = 54
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) cnt_d = CW'(DIV - 1);
   end

   assign tick = (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= CW'(DIV - 1);
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote, false-start rejection,
// parity/frame/break detection and a valid/ready holding register.
//
// state  | meaning
// IDLE   | waiting for a low sample while armed
// START  | verifying start bit at mid-point
// DATA   | shifting data bits LSB first
// PARITY | sampling parity bit (only when parity enabled)
// STOP   | sampling stop bit(s); frame completes at vote of last one
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BAUD        = 115200,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 busy
);

   localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam parity_e PAR_MODE = parity_e'(PARITY);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_V0   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_V1   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_V2   = TW'(OVERSAMPLE / 2 + 1);

   generate
      if (DIV < 2) begin : g_div_chk
         $error("uart_rx_os: clock divider below 2");
      end
      if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
          (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
          (SYNC_STAGES < 2)) begin : g_par_chk
         $error("uart_rx_os: illegal parameter combination");
      end
   endgenerate

   logic tick;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxd_s;
   rx_state_e              state_q, state_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [TW-1:0]          hcnt_q, hcnt_d;
   logic                   armed_q, armed_d;
   logic [3:0]             bcnt_q, bcnt_d;
   logic [1:0]             samp_q, samp_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ones_q, ones_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   rx_flags_t              flags_q, flags_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;

   logic                   vote;
   logic                   frame_done;
   logic                   brk;
   logic                   accept;
   logic                   load;
   logic [DATA_BITS-1:0]   new_data;
   rx_flags_t              new_flags;

   assign rxd_s = sync_q[SYNC_STAGES-1];
   assign vote  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      hcnt_d     = hcnt_q;
      armed_d    = armed_q;
      bcnt_d     = bcnt_q;
      samp_d     = samp_q;
      shreg_d    = shreg_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      ones_d     = ones_q;
      frame_done = 1'b0;
      brk        = 1'b0;
      new_data   = '0;
      new_flags  = '0;

      // Arming: only a full bit-time of idle line enables start detection.
      if (!armed_q && tick) begin
         if (rxd_s) begin
            if (hcnt_q == T_LAST) armed_d = 1'b1;
            else                  hcnt_d  = hcnt_q + TW'(1);
         end else begin
            hcnt_d = '0;
         end
      end

      if (state_q == IDLE) begin
         if (tick && armed_q && !rxd_s) begin
            state_d = START;
            tcnt_d  = '0;
            bcnt_d  = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ones_d  = 1'b0;
         end
      end else if (tick) begin
         tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);
         if (tcnt_q == T_V0) samp_d[0] = rxd_s;
         if (tcnt_q == T_V1) samp_d[1] = rxd_s;

         case (state_q)
            START: begin
               if (tcnt_q == T_V2 && vote) state_d = IDLE;
               else if (tcnt_q == T_LAST)  state_d = DATA;
            end
            DATA: begin
               if (tcnt_q == T_V2) begin
                  shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                  ones_d  = ones_q | vote;
               end
               if (tcnt_q == T_LAST) begin
                  if (bcnt_q == 4'(DATA_BITS - 1)) begin
                     bcnt_d  = '0;
                     state_d = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
                  end else begin
                     bcnt_d = bcnt_q + 4'd1;
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (tcnt_q == T_V2) begin
                  ones_d = ones_q | vote;
                  perr_d = (((^shreg_q) ^ vote) != (PAR_MODE == PAR_ODD));
               end
               if (tcnt_q == T_LAST) state_d = STOP;
            end
            STOP: begin
               if (tcnt_q == T_V2) begin
                  ones_d = ones_q | vote;
                  if (!vote) ferr_d = 1'b1;
                  if (bcnt_q == 4'(STOP_BITS - 1)) begin
                     frame_done = 1'b1;
                     state_d    = IDLE;
                  end
               end
               if (tcnt_q == T_LAST) bcnt_d = bcnt_q + 4'd1;
            end
            default: state_d = IDLE;
         endcase
      end

      // A break word masks parity so the consumer sees a clean break indication.
      if (frame_done) begin
         brk                  = !(ones_q | vote);
         new_data             = brk ? '0 : shreg_q;
         new_flags.parity_err = perr_q & !brk;
         new_flags.frame_err  = ferr_q | !vote;
         new_flags.break_det  = brk;
         if (brk) begin
            armed_d = 1'b0;
            hcnt_d  = '0;
         end
      end
   end

   always_comb begin
      accept  = valid_q & data_ready;
      load    = frame_done & (!valid_q | data_ready);
      data_d  = data_q;
      flags_d = flags_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (load) begin
         data_d  = new_data;
         flags_d = new_flags;
         valid_d = 1'b1;
         ovr_d   = 1'b0;
      end else begin
         if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
         end
         if (frame_done) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '1;
         state_q <= IDLE;
         tcnt_q  <= '0;
         hcnt_q  <= '0;
         armed_q <= 1'b0;
         bcnt_q  <= '0;
         samp_q  <= '0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ones_q  <= 1'b0;
         data_q  <= '0;
         flags_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         hcnt_q  <= hcnt_d;
         armed_q <= armed_d;
         bcnt_q  <= bcnt_d;
         samp_q  <= samp_d;
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ones_q  <= ones_d;
         data_q  <= data_d;
         flags_q <= flags_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign parity_err = flags_q.parity_err;
   assign frame_err  = flags_q.frame_err;
   assign break_det  = flags_q.break_det;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and an even-parity instance driven
// with directed and random frames, checked against a frame-level model.
module tb_uart_rx_os;

   localparam int CLK_FREQ = 100_000_000;
   localparam int BAUD     = 1_562_500;
   localparam int OS       = 16;
   localparam int DIV      = 4;
   localparam int BIT      = OS * DIV;
   localparam int SHORT0   = 12 * DIV;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       bd;
   } word_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd_a = 1'b1, rxd_b = 1'b1;
   logic       ready_a = 1'b1, ready_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, pe_a, pe_b, fe_a, fe_b, bd_a, bd_b;
   logic       ovr_a, ovr_b, busy_a, busy_b;

   int n_chk = 0;
   int n_err = 0;
   int vcnt_a = 0;
   word_t q_a[$];
   word_t q_b[$];

   always #5 clk = ~clk;

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .rxd(rxd_a), .data(data_a), .data_valid(valid_a),
      .data_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a),
      .overrun(ovr_a), .busy(busy_a));

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst(rst), .rxd(rxd_b), .data(data_b), .data_valid(valid_b),
      .data_ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b),
      .overrun(ovr_b), .busy(busy_b));

   // Words the consumer takes: valid & ready seen mid-cycle are accepted at the next edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_a) vcnt_a++;
         if (valid_a && ready_a) q_a.push_back('{data_a, pe_a, fe_a, bd_a});
         if (valid_b && ready_b) q_b.push_back('{data_b, pe_b, fe_b, bd_b});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) rxd_b = v;
      else     rxd_a = v;
   endtask

   // Frame-level reference: what the receiver must report for a frame of these bits.
   function automatic word_t model(input logic [7:0] d, input int par_mode,
                                   input logic pbit, input logic stop);
      word_t w;
      logic  brk;
      brk  = (d == 8'h00) && (par_mode == 0 || pbit == 1'b0) && (stop == 1'b0);
      w.d  = brk ? 8'h00 : d;
      w.fe = !stop;
      w.bd = brk;
      w.pe = 1'b0;
      if (par_mode != 0 && !brk) begin
         if (par_mode == 1) w.pe = ((^d) ^ pbit) != 1'b1;
         else               w.pe = ((^d) ^ pbit) != 1'b0;
      end
      return w;
   endfunction

   // A zero stop bit is held only ~12 ticks so the tail cannot look like a new start.
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit par,
                             input logic pbit, input logic stop, input int rst_bit);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (par) bits.push_back(pbit);
      bits.push_back(stop);
      for (int i = 0; i < bits.size(); i++) begin
         set_line(sel, bits[i]);
         if (i == rst_bit) begin
            wait_clks(10);
            rst = 1'b1;
            wait_clks(3);
            rst = 1'b0;
            wait_clks(BIT - 13);
         end else if (i == bits.size() - 1 && bits[i] == 1'b0) begin
            wait_clks(SHORT0);
         end else begin
            wait_clks(BIT);
         end
      end
      set_line(sel, 1'b1);
   endtask

   task automatic expect_word(input string tag, input bit sel, input word_t exp);
      int    t;
      word_t w;
      t = 0;
      while ((sel ? q_b.size() : q_a.size()) == 0 && t < 2 * BIT) begin
         wait_clks(1);
         t++;
      end
      chk({tag, "_cnt"}, sel ? q_b.size() : q_a.size(), 1);
      if ((sel ? q_b.size() : q_a.size()) != 0) begin
         w = sel ? q_b.pop_front() : q_a.pop_front();
         chk({tag, "_data"}, w.d, exp.d);
         chk({tag, "_perr"}, w.pe, exp.pe);
         chk({tag, "_ferr"}, w.fe, exp.fe);
         chk({tag, "_brk"}, w.bd, exp.bd);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s;

      wait_clks(3);
      chk("rst_data", data_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_flags", {pe_a, fe_a, bd_a}, 0);
      chk("rst_ovr", ovr_a, 0);
      chk("rst_busy", busy_a, 0);
      rst = 1'b0;
      wait_clks(2 * BIT);

      // 8N1 single word, single-cycle valid
      vcnt_a = 0;
      send_frame(0, 8'hA5, 0, 0, 1, -1);
      wait_clks(BIT);
      expect_word("t1", 0, model(8'hA5, 0, 0, 1));
      chk("t1_vpulse", vcnt_a, 1);

      // even parity, wrong then right parity bit
      send_frame(1, 8'h07, 1, 0, 1, -1);
      wait_clks(BIT);
      expect_word("t2_bad", 1, model(8'h07, 2, 0, 1));
      send_frame(1, 8'h07, 1, 1, 1, -1);
      wait_clks(BIT);
      expect_word("t2_good", 1, model(8'h07, 2, 1, 1));

      // false start
      rxd_a = 1'b0;
      wait_clks(4 * DIV);
      chk("t3_busy_in_start", busy_a, 1);
      rxd_a = 1'b1;
      wait_clks(12 * DIV);
      chk("t3_busy_idle", busy_a, 0);
      chk("t3_no_word", q_a.size(), 0);
      wait_clks(BIT);
      send_frame(0, 8'h3C, 0, 0, 1, -1);
      wait_clks(BIT);
      expect_word("t3", 0, model(8'h3C, 0, 0, 1));

      // framing error, then break and re-arm
      send_frame(0, 8'h55, 0, 0, 0, -1);
      wait_clks(2 * BIT);
      expect_word("t4_frame", 0, model(8'h55, 0, 0, 0));
      rxd_a = 1'b0;
      wait_clks(20 * BIT);
      expect_word("t4_break", 0, model(8'h00, 0, 0, 0));
      chk("t4_one_word", q_a.size(), 0);
      rxd_a = 1'b1;
      wait_clks(5 * DIV);
      send_frame(0, 8'h00, 0, 0, 1, -1);
      wait_clks(2 * BIT);
      chk("t4_not_armed", q_a.size(), 0);
      send_frame(0, 8'h5A, 0, 0, 1, -1);
      wait_clks(BIT);
      expect_word("t4_rearm", 0, model(8'h5A, 0, 0, 1));

      // overrun
      ready_a = 1'b0;
      send_frame(0, 8'h11, 0, 0, 1, -1);
      send_frame(0, 8'h22, 0, 0, 1, -1);
      wait_clks(BIT);
      chk("t5_held", data_a, 8'h11);
      chk("t5_valid", valid_a, 1);
      chk("t5_ovr", ovr_a, 1);
      ready_a = 1'b1;
      wait_clks(1);
      ready_a = 1'b0;
      chk("t5_valid_after", valid_a, 0);
      chk("t5_ovr_after", ovr_a, 0);
      expect_word("t5_acc", 0, model(8'h11, 0, 0, 1));
      ready_a = 1'b1;
      wait_clks(2 * BIT);
      chk("t5_no_22", q_a.size(), 0);

      // reset in the middle of data bit 6
      send_frame(0, 8'h3C, 0, 0, 1, 7);
      wait_clks(3 * BIT);
      chk("t6_no_word", q_a.size(), 0);
      chk("t6_valid", valid_a, 0);
      send_frame(0, 8'h3C, 0, 0, 1, -1);
      wait_clks(BIT);
      expect_word("t6", 0, model(8'h3C, 0, 0, 1));

      // random frames on both instances
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom_range(0, 255));
         if (k == 3) d = 8'h00;
         s = ($urandom_range(0, 3) != 0);
         send_frame(0, d, 0, 0, s, -1);
         wait_clks(2 * BIT);
         expect_word("rnd_a", 0, model(d, 0, 0, s));
      end
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 3) != 0);
         send_frame(1, d, 1, p, s, -1);
         wait_clks(2 * BIT);
         expect_word("rnd_b", 1, model(d, 2, p, s));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
